// File: rtl/mem_access_seq_if.sv
// Bus bundle between the control unit, the memory access sequencer and RAM.
// Carries the request strobe and attributes (start/rw/size/sgn/addr/wdata),
// the RAM-side handshake and data (MFA/MFC/mem_*), and the results back to
// the datapath (rdata/busy/done/align_trap/tmo_trap).
//   slave  : view taken by mem_access_seq
//   master : view taken by the surrounding control unit / RAM (or a bench)
interface mem_access_seq_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              start;
  logic              rw;
  logic [1:0]        size;
  logic              sgn;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              MFA;
  logic              MFC;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_be;
  logic              mem_we;
  logic [31:0]       mem_rdata;
  logic [31:0]       rdata;
  logic              busy;
  logic              done;
  logic              align_trap;
  logic              tmo_trap;

  modport slave (
    input  start, rw, size, sgn, addr, wdata, MFC, mem_rdata,
    output MFA, mem_addr, mem_wdata, mem_be, mem_we, rdata,
           busy, done, align_trap, tmo_trap
  );

  modport master (
    output start, rw, size, sgn, addr, wdata, MFC, mem_rdata,
    input  MFA, mem_addr, mem_wdata, mem_be, mem_we, rdata,
           busy, done, align_trap, tmo_trap
  );
endinterface

// File: rtl/mem_access_seq.sv
// Memory access sequencer between MAR/MDR and RAM.
// One start pulse runs a complete MFA/MFC four-phase handshake with
// byte/halfword/word sizing, big-endian lane steering, load sign/zero
// extension, misalignment trap and MFC timeout trap.
// Ports:
//   Clk  : rising-edge clock
//   Rst  : synchronous active-high reset
//   bus  : mem_access_seq_if.slave (request, RAM handshake/data, results)
module mem_access_seq #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 15,
  parameter int unsigned CNT_W       = 4
) (
  input logic              Clk,
  input logic              Rst,
  mem_access_seq_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_TRAP,
    S_RELEASE
  } state_t;

  state_t            state_q, state_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mfa_q, mfa_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              align_q, align_d;
  logic              tmo_q, tmo_d;

  logic              aligned;
  logic [3:0]        be_req;
  logic [31:0]       wdata_req;
  logic [31:0]       rd_shift;
  logic [31:0]       rd_ext;
  logic [CNT_W-1:0]  cnt_inc;

  // Request decode: alignment check and store lane steering from live inputs.
  always_comb begin
    aligned   = 1'b0;
    be_req    = '0;
    wdata_req = '0;
    case (bus.size)
      2'b00: begin
        aligned   = 1'b1;
        be_req    = 4'b1000 >> bus.addr[1:0];
        wdata_req = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        aligned   = ~bus.addr[0];
        be_req    = bus.addr[1] ? 4'b0011 : 4'b1100;
        wdata_req = {2{bus.wdata[15:0]}};
      end
      2'b10: begin
        aligned   = (bus.addr[1:0] == 2'b00);
        be_req    = 4'b1111;
        wdata_req = bus.wdata;
      end
      default: aligned = 1'b0;
    endcase
  end

  // Load extraction: shifting left by 8*offset moves the addressed big-endian
  // lane to the top of the word, so one slice serves every offset.
  always_comb begin
    rd_shift = bus.mem_rdata << {off_q, 3'b000};
    case (size_q)
      2'b00:   rd_ext = {{24{sgn_q & rd_shift[31]}}, rd_shift[31:24]};
      2'b01:   rd_ext = {{16{sgn_q & rd_shift[31]}}, rd_shift[31:16]};
      default: rd_ext = rd_shift;
    endcase
  end

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    rw_d        = rw_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mfa_d       = mfa_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    mem_we_d    = mem_we_q;
    rdata_d     = rdata_q;
    done_d      = 1'b0;
    align_d     = 1'b0;
    tmo_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.start) begin
          if (aligned) begin
            rw_d        = bus.rw;
            size_d      = bus.size;
            sgn_d       = bus.sgn;
            off_d       = bus.addr[1:0];
            mem_addr_d  = {bus.addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = be_req;
            mem_we_d    = ~bus.rw;
            mem_wdata_d = wdata_req;
            mfa_d       = 1'b1;
            state_d     = S_REQ;
          end else begin
            align_d = 1'b1;
            state_d = S_TRAP;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_inc;
        // MFC is tested first so it wins over a coincident timeout.
        if (bus.MFC) begin
          if (rw_q) begin
            rdata_d = rd_ext;
          end
          mfa_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
          mfa_d   = 1'b0;
          tmo_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_DONE:    state_d = S_RELEASE;
      S_TRAP:    state_d = S_IDLE;
      S_RELEASE: begin
        if (!bus.MFC) begin
          state_d = S_IDLE;
        end
      end
      default:   state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q     <= S_IDLE;
      rw_q        <= 1'b0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      off_q       <= '0;
      cnt_q       <= '0;
      mfa_q       <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      align_q     <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rw_q        <= rw_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mfa_q       <= mfa_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      mem_we_q    <= mem_we_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      align_q     <= align_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.MFA        = mfa_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.rdata      = rdata_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.align_trap = align_q;
  assign bus.tmo_trap   = tmo_q;

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Parametrised memory access sequencer between the datapath's MAR/MDR and the RAM.
- Owns the MFA/MFC handshake and byte/halfword/word sizing with big-endian lane steering.
- Handles sign/zero extension, misalignment detection and an MFC timeout.
- Replaces hand-sequenced MFA toggling; the control unit issues one start pulse and waits for done or a trap.

Parameters:
- ADDR_W, 8, byte-address width presented to RAM.
- TIMEOUT_CYC, 15, maximum REQ-state cycles without MFC before timeout trap (1..2^CNT_W-1).
- CNT_W, 4, width of timeout counter.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle request strobe; sampled only in IDLE.
- rw  in  1  1=read (load), 0=write (store).
- size  in  2  00=byte, 01=halfword, 10=word, 11=reserved (treated as misaligned).
- sgn  in  1  sign-extend read data when 1.
- addr  in  ADDR_W  byte address (from MAR).
- wdata  in  32  store data, right-justified (from MDR).
- MFA  out  1  memory function active to RAM.
- MFC  in  1  memory function complete from RAM.
- mem_addr  out  ADDR_W  word-aligned address (addr with [1:0] forced to 0).
- mem_wdata  out  32  lane-steered store data.
- mem_be  out  4  byte enables; bit3 = bits 31:24.
- mem_we  out  1  1 during write requests.
- mem_rdata  in  32  aligned word from RAM.
- rdata  out  32  extended load result (to MDR_MUX).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle completion pulse.
- align_trap  out  1  one-cycle misalignment pulse.
- tmo_trap  out  1  one-cycle timeout pulse.

Behaviour:
- Reset: state=IDLE. MFA, mem_we, busy, done, align_trap and tmo_trap are 0. mem_be=0, mem_addr=0, mem_wdata=0, rdata=0, counter=0. Rst overrides everything, including mid-REQ: MFA drops on the next edge and the pending access is abandoned with no done.
- States: IDLE, REQ, DONE, TRAP, RELEASE.
- IDLE, start=1, aligned: latch rw, size, sgn and addr[1:0]; drive mem_addr, mem_be, mem_we and mem_wdata; go to REQ. MFA is asserted from the first REQ cycle.
- Alignment rules:
  - halfword requires addr[0]=0.
  - word requires addr[1:0]=0.
  - size=11 is always misaligned.
  - On misalignment go to TRAP: align_trap=1 for 1 cycle, MFA never asserted, then IDLE.
- Lane steering (big-endian, offset o=addr[1:0]):
  - byte: mem_be=1000>>o; wdata[7:0] replicated in all four lanes.
  - half: mem_be=1100 (o=0) or 0011 (o=2); wdata[15:0] replicated in both halves.
  - word: mem_be=1111, mem_wdata=wdata.
- REQ:
  - MFA=1; counter increments each cycle.
  - MFC=1: capture the extracted lane into rdata (reads only; writes leave rdata unchanged), clear MFA, go to DONE.
  - counter reaches TIMEOUT_CYC with MFC=0: clear MFA, pulse tmo_trap, go to RELEASE.
  - MFC and timeout in the same cycle: MFC wins.
- Read extraction:
  - byte = mem_rdata[31-8o -: 8].
  - half = mem_rdata[31-8o -: 16].
  - Upper bits are zero, or copies of the lane MSB when sgn=1.
- DONE: done=1 for exactly 1 cycle, then RELEASE.
- RELEASE: wait until MFC=0 (four-phase handshake), then IDLE. If MFC is already 0, this takes one cycle.
- Latency: a load with zero-wait RAM (MFC one cycle after MFA) gives start at T, REQ at T+1, MFC seen at T+1 edge, done at T+2, idle at T+4.
- start while busy=1 is ignored (no queuing).
- mem_addr, mem_be, mem_we and mem_wdata hold stable from REQ entry until IDLE re-entry.

Test Plan:
- Word load: addr=0x04, RAM word 0xA2044012, MFC after 2 cycles -> rdata=0xA2044012, done one pulse, MFA high exactly 3 cycles.
- Signed byte load: addr=0x07 (o=3), mem_rdata=0x123456F0, sgn=1 -> rdata=0xFFFFFFF0. Same with sgn=0 -> 0x000000F0.
- Halfword store: addr=0x0A, wdata=0x0000BEEF -> mem_be=0011, mem_wdata=0xBEEFBEEF, mem_we=1, mem_addr=0x08, done pulses.
- Misaligned word: addr=0x06, size=10 -> align_trap one pulse, MFA stays 0, busy high 1 cycle, no done.
- Timeout: MFC held 0 -> tmo_trap pulses after 15 REQ cycles, MFA drops. A start issued during REQ is ignored; the next start is accepted after return to IDLE.
- Rst asserted on the 3rd REQ cycle -> next cycle MFA=0, busy=0, no done/trap. MFC stuck high afterward: a new start is accepted and completes through RELEASE only after MFC falls.
